// File: rtl/dds_sine_gen.sv
// DDS sine generator: phase accumulator + static offset addressing a quarter-wave sine table.
// Optional macro DDS_ADDR_PIPE_EN registers the table address, giving 2-clock phase-to-out latency.
module dds_sine_gen #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned AMP   = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] freq_res,
    input  logic [7:0] phase,
    output logic [7:0] out
);

    // round(AMP*sin(k*pi/128)) for k in 0..64, computed at elaboration with a Q30 Taylor series.
    function automatic logic [6:0] quarter_sine(input int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint mag;
        x    = (longint'(k) * 64'sd3373259426) / 64'sd128;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        mag = (longint'(AMP) * sum + (64'sd1 <<< 29)) >>> 30;
        return mag[6:0];
    endfunction

    logic [6:0] qtbl [0:64];

    for (genvar g = 0; g <= 64; g++) begin : g_qtbl
        localparam logic [6:0] QVal = quarter_sine(g);
        assign qtbl[g] = QVal;
    end

    logic [ACC_W-1:0] acc;
    logic [7:0]       addr;
    logic [7:0]       lut_addr;
    logic [6:0]       mag_idx;
    logic [7:0]       mag;
    logic [7:0]       sample;

    assign addr = acc[ACC_W-1 -: 8] + phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else begin
            acc <= acc + {{(ACC_W - 6){1'b0}}, freq_res};
        end
    end

`ifdef DDS_ADDR_PIPE_EN
    logic [7:0] addr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= 8'd0;
        end else begin
            addr_reg <= addr;
        end
    end

    assign lut_addr = addr_reg;
`else
    assign lut_addr = addr;
`endif

    // Second and fourth quadrants mirror the index; the top half negates the magnitude.
    always_comb begin
        mag_idx = lut_addr[6] ? (7'd64 - {1'b0, lut_addr[5:0]}) : {1'b0, lut_addr[5:0]};
        mag     = {1'b0, qtbl[mag_idx]};
        sample  = lut_addr[7] ? (8'd0 - mag) : mag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= 8'd0;
        end else begin
            out <= sample;
        end
    end

endmodule

// File: tb/tb_dds_sine_gen.sv
// Scoreboard bench for dds_sine_gen: a reference model pushes expected samples, a negedge
// monitor pops and compares; directed checks cover reset, static phase and sweep key points.
module tb_dds_sine_gen;

`ifdef DDS_ADDR_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic       clk;
    logic       rst;
    logic [5:0] freq_res;
    logic [7:0] phase;
    logic [7:0] out;

    int checks   = 0;
    int failures = 0;
    int sb[$];

    int m_acc    = 0;
    int m_addr_q = 0;
    int m_out    = 0;

    int kidx[8]   = '{0, 512, 1024, 2048, 4096, 6144, 7168, 8192};
    int kval0[8]  = '{0, 49, 90, 127, 0, -127, -90, 0};
    int kval64[8] = '{127, 117, 90, 0, -127, 0, 90, 127};
    int spha[5]   = '{0, 32, 64, 128, 192};
    int sval[5]   = '{0, 90, 127, 0, -127};

    dds_sine_gen #(
        .ACC_W(16),
        .AMP  (127)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .freq_res(freq_res),
        .phase   (phase),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_ref(input int a);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(a % 256) / 256.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one sample per clock, compared against the oldest expected entry.
    always @(negedge clk) begin
        int v;
        if (sb.size() > 0) begin
            v = int'($signed(out));
            chk("sample", v, sb.pop_front());
            chk("range", int'(v >= -127 && v <= 127), 1);
        end
    end

    task automatic step(input logic [5:0] f, input logic [7:0] p);
        freq_res = f;
        phase    = p;
        @(posedge clk);
        if (PIPE != 0) begin
            m_out    = s_ref(m_addr_q);
            m_addr_q = ((m_acc >> 8) + int'(p)) & 255;
        end else begin
            m_out = s_ref(((m_acc >> 8) + int'(p)) & 255);
        end
        m_acc = (m_acc + int'(f)) & 16'hffff;
        #1;
        sb.push_back(m_out);
    endtask

    // Entered at posedge+1; asserts rst between edges after the monitor has consumed the queue.
    task automatic do_reset();
        #6;
        rst = 1'b0;
        #1;
        chk("reset_async", int'($signed(out)), 0);
        m_acc    = 0;
        m_addr_q = 0;
        m_out    = 0;
        sb.delete();
        freq_res = 6'd8;
        phase    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", int'($signed(out)), 0);
        rst = 1'b1;
    endtask

    task automatic run(input logic [5:0] f, input logic [7:0] p, input int n, input bit mono);
        int s;
        int cur;
        int prev;
        int quad;
        int bad;
        bad  = 0;
        prev = 0;
        for (int k = 0; k < n; k++) begin
            step(f, p);
            s   = k - PIPE;
            cur = int'($signed(out));
            if (f == 6'd8 && s >= 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (s == kidx[i]) begin
                        if (p == 8'd0) chk("sweep_key", cur, kval0[i]);
                        else if (p == 8'd64) chk("cosine_key", cur, kval64[i]);
                    end
                end
            end
            if (mono && s > 0 && (s % 2048) != 0) begin
                quad = (s / 2048) % 4;
                if ((quad == 0 || quad == 3) ? (cur < prev) : (cur > prev)) bad++;
            end
            prev = cur;
        end
        if (mono) chk("monotonic", bad, 0);
    endtask

    initial begin
        rst      = 1'b1;
        freq_res = 6'd8;
        phase    = 8'd0;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            step(6'd0, 8'(spha[i]));
            step(6'd0, 8'(spha[i]));
            chk("static_phase", int'($signed(out)), sval[i]);
        end

        do_reset();
        run(6'd8, 8'd0, 8193 + PIPE, 1'b1);

        do_reset();
        run(6'd8, 8'd64, 5001, 1'b0);
        do_reset();
        run(6'd8, 8'd64, 1100, 1'b0);

        do_reset();
        run(6'd63, 8'd37, 20000, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
